// File: rtl/la_probe_capture.sv
// rtl/la_probe_capture.sv - triggered full-width probe capture buffer with in-order host drain
module la_probe_capture #(
    parameter int NCH   = 8,
    parameter int CH_W  = 32,
    parameter int DEPTH = 16,
    localparam int SELW = $clog2(NCH),
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [NCH*CH_W-1:0] probe_i,
    input  logic [SELW-1:0]     sel_i,
    input  logic [CH_W-1:0]     trig_mask_i,
    input  logic [CH_W-1:0]     trig_val_i,
    input  logic [CNTW-1:0]     post_i,
    input  logic                arm_i,
    input  logic                abort_i,
    input  logic                rd_i,
    output logic [CH_W-1:0]     rd_data_o,
    output logic                rd_valid_o,
    output logic [CNTW-1:0]     count_o,
    output logic [1:0]          state_o,
    output logic                irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [SELW:0]   NCH_C   = (SELW + 1)'(NCH);
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] ONE_C   = CNTW'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

    state_t          state;
    logic [SELW-1:0] sel_q;
    logic [CH_W-1:0] mask_q;
    logic [CH_W-1:0] val_q;
    logic [CNTW-1:0] post_q;
    logic [CNTW-1:0] count;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            irq;
    logic [CH_W-1:0] mem [DEPTH];

    logic [CH_W-1:0] sample;
    logic [CNTW-1:0] count_inc;
    logic            hit;
    logic            wr_en;
    logic            arm_ok;

    assign sample    = probe_i[sel_q*CH_W +: CH_W];
    assign hit       = ((sample & mask_q) == (val_q & mask_q));
    assign count_inc = count + 1'b1;
    // arm is only honoured when no capture is in flight
    assign arm_ok    = arm_i && (state == IDLE || state == DONE);
    assign wr_en     = !wb_rst_i && !abort_i &&
                       ((state == ARMED && hit) || state == CAPTURE);

    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= sample;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state  <= IDLE;
            sel_q  <= '0;
            mask_q <= '0;
            val_q  <= '0;
            post_q <= '0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            irq    <= 1'b0;
        end else begin
            irq <= 1'b0;
            if (abort_i) begin
                state  <= IDLE;
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else if (arm_ok) begin
                sel_q  <= ({1'b0, sel_i} >= NCH_C) ? '0 : sel_i;
                mask_q <= trig_mask_i;
                val_q  <= trig_val_i;
                post_q <= (post_i == '0)     ? ONE_C   :
                          (post_i > DEPTH_C) ? DEPTH_C : post_i;
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                state  <= ARMED;
            end else begin
                case (state)
                    ARMED: begin
                        if (hit) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            count  <= ONE_C;
                            if (post_q == ONE_C) begin
                                state <= DONE;
                                irq   <= 1'b1;
                            end else begin
                                state <= CAPTURE;
                            end
                        end
                    end
                    CAPTURE: begin
                        wr_ptr <= wr_ptr + 1'b1;
                        count  <= count_inc;
                        if (count_inc == post_q) begin
                            state <= DONE;
                            irq   <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (rd_i && count != '0) begin
                            rd_ptr <= rd_ptr + 1'b1;
                            count  <= count - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign state_o    = state;
    assign count_o    = count;
    assign irq_o      = irq;
    assign rd_valid_o = (state == DONE) && (count != '0);
    assign rd_data_o  = rd_valid_o ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_la_probe_capture.sv
// tb/tb_la_probe_capture.sv - directed bench with queue-based reference model for la_probe_capture
module tb_la_probe_capture;
    localparam int NCH = 6, CH_W = 32, DEPTH = 16, SELW = 3, CNTW = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NCH*CH_W-1:0] probe;
    logic [CH_W-1:0]     ch [NCH];
    logic [SELW-1:0]     sel;
    logic [CH_W-1:0]     mask, val;
    logic [CNTW-1:0]     post;
    logic                arm, abort, rd;
    logic [CH_W-1:0]     rd_data;
    logic                rd_valid, irq;
    logic [CNTW-1:0]     count;
    logic [1:0]          state;

    always #5 clk = ~clk;

    always_comb begin
        probe = '0;
        for (int k = 0; k < NCH; k++) probe[k*CH_W +: CH_W] = ch[k];
    end

    la_probe_capture #(.NCH(NCH), .CH_W(CH_W), .DEPTH(DEPTH)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .probe_i(probe), .sel_i(sel),
        .trig_mask_i(mask), .trig_val_i(val), .post_i(post), .arm_i(arm),
        .abort_i(abort), .rd_i(rd), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .count_o(count), .state_o(state), .irq_o(irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: captured samples live in a queue, mode is 0 idle/1 armed/2 capture/3 done
    bit              m_live = 1'b0;
    int              m_mode = 0;
    int              m_sel = 0, m_post = 0;
    logic [31:0]     m_mask = '0, m_val = '0;
    logic [31:0]     m_q[$];
    bit              m_irq = 1'b0;

    task automatic m_arm();
        m_sel  = (int'(sel) >= NCH) ? 0 : int'(sel);
        m_mask = mask;
        m_val  = val;
        m_post = (post == 0) ? 1 : (int'(post) > DEPTH) ? DEPTH : int'(post);
        m_q.delete();
        m_mode = 1;
    endtask

    always @(posedge clk) begin
        logic [31:0] s;
        m_irq = 1'b0;
        s = ch[m_sel];
        if (rst) begin
            m_live = 1'b1; m_mode = 0; m_q.delete();
            m_sel = 0; m_post = 0; m_mask = '0; m_val = '0;
        end else if (abort) begin
            m_mode = 0; m_q.delete();
        end else begin
            case (m_mode)
                0: if (arm) m_arm();
                1: if (((s ^ m_val) & m_mask) == 0) begin
                       m_q.push_back(s);
                       if (m_q.size() >= m_post) begin m_mode = 3; m_irq = 1'b1; end
                       else m_mode = 2;
                   end
                2: begin
                       m_q.push_back(s);
                       if (m_q.size() == m_post) begin m_mode = 3; m_irq = 1'b1; end
                   end
                default: if (arm) m_arm();
                         else if (rd && m_q.size() > 0) void'(m_q.pop_front());
            endcase
        end
        #1;
        if (m_live) begin
            chk("m_state", state, m_mode);
            chk("m_count", count, m_q.size());
            chk("m_irq", irq, m_irq);
            chk("m_valid", rd_valid, (m_mode == 3 && m_q.size() > 0));
            chk("m_data", rd_data, (m_mode == 3 && m_q.size() > 0) ? m_q[0] : 32'h0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int t;
        rst = 1'b1; arm = 1'b0; abort = 1'b0; rd = 1'b0;
        sel = '0; mask = '0; val = '0; post = '0;
        for (int k = 0; k < NCH; k++) ch[k] = 32'hBAD0 + k;
        tick(); tick();
        rst = 1'b0;
        chk("t1_state", state, 0); chk("t1_count", count, 0);
        chk("t1_valid", rd_valid, 0); chk("t1_irq", irq, 0); chk("t1_data", rd_data, 0);

        // immediate trigger, ch2 ramps 10,11,.. from the arm cycle
        sel = 3'd2; mask = '0; val = 32'hFFFF; post = 5'd4;
        arm = 1'b1; ch[2] = 10; tick(); arm = 1'b0;
        chk("t2_armed", state, 1);
        ch[2] = 11; tick();
        chk("t2_capture", state, 2); chk("t2_cnt1", count, 1);
        ch[2] = 12; tick(); ch[2] = 13; tick(); ch[2] = 14; tick();
        chk("t2_done", state, 3); chk("t2_irq", irq, 1);
        chk("t2_count", count, 4); chk("t2_first", rd_data, 11);
        ch[2] = 15; tick();
        chk("t2_irq_once", irq, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t2_read", rd_data, 11 + i);
            rd = 1'b1; tick(); rd = 1'b0;
        end
        chk("t2_empty_valid", rd_valid, 0); chk("t2_empty_data", rd_data, 0);
        rd = 1'b1; tick(); rd = 1'b0;
        chk("t2_rd_empty", count, 0);

        // masked trigger on low byte of ch5; ch2 carries the pattern as a decoy
        sel = 3'd5; mask = 32'hFF; val = 32'h5A; post = 5'd3; ch[2] = 32'h5A;
        for (t = 0; t < 10; t++) begin
            ch[5] = (t == 7) ? 32'h5A : 32'h1200 + t;
            arm = (t == 0);
            tick();
            if (t == 6) chk("t3_wait", state, 1);
        end
        arm = 1'b0;
        chk("t3_done", state, 3); chk("t3_irq", irq, 1); chk("t3_count", count, 3);
        chk("t3_e0", rd_data, 32'h5A);    rd = 1'b1; tick();
        chk("t3_e1", rd_data, 32'h1208);  tick();
        chk("t3_e2", rd_data, 32'h1209);  tick(); rd = 1'b0;
        chk("t3_drained", rd_valid, 0);

        // abort mid-capture, then arm+abort together in idle
        sel = 3'd0; mask = '0; post = 5'd8;
        for (t = 0; t < 4; t++) begin
            ch[0] = 32'h40 + t; arm = (t == 0); tick();
        end
        arm = 1'b0;
        chk("t4_capturing", state, 2); chk("t4_cnt", count, 3);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t4_abort_state", state, 0); chk("t4_abort_cnt", count, 0); chk("t4_abort_irq", irq, 0);
        tick(); tick();
        chk("t4_no_irq", irq, 0);
        arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
        chk("t4_arm_abort", state, 0);

        // post=0 clamps to 1, out-of-range sel falls back to ch0
        sel = 3'd7; post = 5'd0; mask = '0;
        ch[0] = 32'hC0DE0000; arm = 1'b1; tick(); arm = 1'b0;
        ch[0] = 32'hC0DE0001; tick();
        chk("t5_one_done", state, 3); chk("t5_one_cnt", count, 1);
        chk("t5_one_irq", irq, 1); chk("t5_ch0", rd_data, 32'hC0DE0001);
        rd = 1'b1; tick(); rd = 1'b0;

        // post=31 clamps to DEPTH; full buffer drained across the pointer wrap
        sel = 3'd3; post = 5'd31;
        ch[3] = 32'h300; arm = 1'b1; tick(); arm = 1'b0;
        t = 1;
        while (state != 2'd3 && t < 40) begin
            ch[3] = 32'h300 + t; tick(); t++;
        end
        chk("t5_full_done", state, 3); chk("t5_full_cnt", count, 16);
        for (int i = 0; i < 16; i++) begin
            chk("t5_full_read", rd_data, 32'h301 + i);
            rd = 1'b1; tick(); rd = 1'b0;
        end
        chk("t5_full_empty", count, 0);

        // re-arm with unread data, then reset in the middle of a capture
        sel = 3'd1; post = 5'd5;
        ch[1] = 32'h600; arm = 1'b1; tick(); arm = 1'b0;
        t = 1;
        while (state != 2'd3 && t < 20) begin
            ch[1] = 32'h600 + t; tick(); t++;
        end
        chk("t6_done", state, 3);
        rd = 1'b1; tick(); tick(); rd = 1'b0;
        chk("t6_unread", count, 3);
        arm = 1'b1; tick(); arm = 1'b0;
        chk("t6_rearm_state", state, 1); chk("t6_rearm_cnt", count, 0); chk("t6_rearm_valid", rd_valid, 0);
        tick(); tick();
        chk("t6_recapture", state, 2);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_rst_state", state, 0); chk("t6_rst_cnt", count, 0);
        chk("t6_rst_valid", rd_valid, 0); chk("t6_rst_irq", irq, 0); chk("t6_rst_data", rd_data, 0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
